// File: rtl/ifu_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response channels, decode handshake,
// next-PC redirect and the sticky fault flag.
interface ifu_fetch_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_resp_valid;
  logic [31:0]       imem_resp_data;
  logic              imem_resp_err;
  logic              inst_valid;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              fetch_fault;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
           inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
           inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch stage: REQ -> WAIT -> HOLD per instruction,
// sticky FAULT on bus error or misaligned next PC.
module ifu_fetch #(
  parameter int unsigned            ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]      RESET_PC = ADDR_W'(32'h8000_0000)
) (
  input  logic        clk,
  input  logic        rst,
  ifu_fetch_if.master bus
);

  localparam int unsigned INST_W = 32;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [ADDR_W-1:0] next_pc;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              drop_q, drop_d;
  logic              resp_take;
  logic              req_valid_q, req_valid_d;
  logic              inst_valid_q, inst_valid_d;
  logic              fault_q, fault_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_REQ;
    else     state_q <= state_d;
  end

  // Next state and datapath; drop_q swallows the one late response of a request aborted by reset
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    drop_d    = drop_q;
    next_pc   = bus.redirect_valid ? bus.redirect_pc : pc_q + ADDR_W'(4);
    resp_take = bus.imem_resp_valid && !drop_q;
    if (bus.imem_resp_valid) drop_d = 1'b0;

    case (state_q)
      S_REQ: begin
        if (bus.imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (resp_take) begin
          if (bus.imem_resp_err) begin
            state_d = S_FAULT;
          end else begin
            state_d   = S_HOLD;
            inst_d    = bus.imem_resp_data;
            inst_pc_d = pc_q;
          end
        end
      end
      S_HOLD: begin
        if (bus.inst_ready) begin
          if (next_pc[1:0] != 2'b00) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_REQ;
            pc_d    = next_pc;
          end
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // Output decode from the next state so the flags are registered alongside state_q
  always_comb begin
    req_valid_d  = (state_d == S_REQ);
    inst_valid_d = (state_d == S_HOLD);
    fault_d      = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      req_valid_q  <= 1'b1;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      drop_q       <= ((state_q == S_WAIT) || drop_q) && !bus.imem_resp_valid;
    end else begin
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
      drop_q       <= drop_d;
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.fetch_fault    = fault_q;

endmodule
